da2_sample_sched: RTL

Sample-rate scheduler for the dual-channel DA2 DAC driver. Accepts 12-bit samples for channel 0 and channel 1 over valid/ready handshakes, buffers one sample per channel, and on every sample tick presents both values and pulses `update` to the driver. It then tracks the driver's SYNC frame to completion before the next frame may start. It sits between the signal sources (NCO, FIFO, register file) and the DA2 driver top.

---
 rtl/da2_pkg.sv | 24 ++
 rtl/da2_hold_reg.sv | 58 +++++
 rtl/da2_sample_sched.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/da2_pkg.sv
// -----------------------------------------------------------------------------
// da2_pkg
// Shared definitions for the DA2 sample scheduler slice: sample width, channel
// count, default timing constants and the frame-tracking FSM state encoding.
// -----------------------------------------------------------------------------
package da2_pkg;

  // Sample width of one DA2 channel and the number of channels driven.
  localparam int DA2_WIDTH    = 12;
  localparam int DA2_CHANNELS = 2;

  // Default tick period (50 kS/s at 100 MHz) and the per-state frame timeout.
  localparam int unsigned DA2_SAMPLE_DIV_DEFAULT    = 2000;
  localparam int unsigned DA2_FRAME_TIMEOUT_DEFAULT = 255;

  // Frame-tracking states: idle between frames, waiting for the driver to pull
  // SYNC low, and waiting for SYNC to return high at the end of the frame.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } da2_state_t;

endpackage

// File: rtl/da2_hold_reg.sv
// -----------------------------------------------------------------------------
// da2_hold_reg
// One-deep holding register for a single DA2 channel. A producer offers a
// sample with valid/ready; the scheduler drains it with a one-cycle consume
// strobe on each frame launch.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   in_data       sample offered by the producer
//   in_valid      producer has a sample
//   in_ready      register can take a sample this cycle
//   consume       launch cycle: the scheduler is taking the buffered sample
//   full          a fresh sample is buffered
//   data          buffered sample
//   underrun_set  consume arrived with nothing buffered (one-cycle pulse)
// -----------------------------------------------------------------------------
module da2_hold_reg
  import da2_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DA2_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 consume,
  output logic                 full,
  output logic [DA2_WIDTH-1:0] data,
  output logic                 underrun_set
);

  logic load;

  // The slot frees up in the very cycle it is consumed, so a producer that is
  // already waiting can refill it on the launch edge without losing a tick.
  always_comb begin
    in_ready     = !full || consume;
    load         = in_valid && in_ready;
    underrun_set = consume && !full;
  end

  // A load wins over a consume: when both land on the same edge the old sample
  // has already been handed to the scheduler, and the new one stays buffered
  // for the next frame with full still set.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else begin
      if (load) begin
        data <= in_data;
        full <= 1'b1;
      end else if (consume) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/da2_sample_sched.sv
// -----------------------------------------------------------------------------
// da2_sample_sched
// Sample-rate scheduler for the dual-channel DA2 DAC driver. Buffers one sample
// per channel, launches a frame (new value0/value1 plus a one-cycle update) on
// every sample tick, and follows the driver's SYNC line until the frame is done.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   ch0_data/valid/ready  channel 0 sample handshake
//   ch1_data/valid/ready  channel 1 sample handshake
//   sync_in               driver SYNC, low while a frame shifts (same clock)
//   value0, value1        held sample values to the driver
//   update                one-cycle frame start strobe
//   busy                  a frame is in flight
//   clr_flags             clears all sticky flags (wins over a same-cycle set)
//   underrun              sticky per channel: tick launched with no fresh sample
//   overrun               sticky: tick arrived while a frame was in flight
//   frame_err             sticky: driver SYNC timed out
// -----------------------------------------------------------------------------
module da2_sample_sched
  import da2_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV    = DA2_SAMPLE_DIV_DEFAULT,
  parameter int unsigned FRAME_TIMEOUT = DA2_FRAME_TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DA2_WIDTH-1:0]    ch0_data,
  input  logic                    ch0_valid,
  output logic                    ch0_ready,
  input  logic [DA2_WIDTH-1:0]    ch1_data,
  input  logic                    ch1_valid,
  output logic                    ch1_ready,
  input  logic                    sync_in,
  output logic [DA2_WIDTH-1:0]    value0,
  output logic [DA2_WIDTH-1:0]    value1,
  output logic                    update,
  output logic                    busy,
  input  logic                    clr_flags,
  output logic [DA2_CHANNELS-1:0] underrun,
  output logic                    overrun,
  output logic                    frame_err
);

  // Last count of the tick period and the last cycle allowed in a wait state.
  localparam logic [15:0] TICK_LAST    = 16'(SAMPLE_DIV - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(FRAME_TIMEOUT - 1);

  da2_state_t state, next_state;

  logic [15:0] tick_cnt;
  logic        tick;
  logic [15:0] to_cnt;
  logic        launch;
  logic        timeout;

  logic [DA2_WIDTH-1:0]    in_data   [DA2_CHANNELS];
  logic [DA2_CHANNELS-1:0] in_valid;
  logic [DA2_CHANNELS-1:0] in_ready;
  logic [DA2_CHANNELS-1:0] hold_full;
  logic [DA2_WIDTH-1:0]    hold_data [DA2_CHANNELS];
  logic [DA2_CHANNELS-1:0] underrun_set;

  // Gather the per-channel ports into arrays so the holding registers can be
  // generated in a loop.
  assign in_data[0] = ch0_data;
  assign in_data[1] = ch1_data;
  assign in_valid   = {ch1_valid, ch0_valid};
  assign ch0_ready  = in_ready[0];
  assign ch1_ready  = in_ready[1];

  // One holding register per channel; all of them are drained together on the
  // launch cycle.
  for (genvar ch = 0; ch < DA2_CHANNELS; ch++) begin : g_hold
    da2_hold_reg u_hold (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data[ch]),
      .in_valid     (in_valid[ch]),
      .in_ready     (in_ready[ch]),
      .consume      (launch),
      .full         (hold_full[ch]),
      .data         (hold_data[ch]),
      .underrun_set (underrun_set[ch])
    );
  end

  // Free-running sample clock divider. It never waits for the FSM, so the
  // sample rate stays exact even when frames overrun and ticks get dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A tick in IDLE is the launch. In the wait states the SYNC
  // edge is checked before the timeout so a frame that finishes on the last
  // permitted cycle is still accepted as good.
  always_comb begin
    next_state = state;
    launch     = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          launch     = 1'b1;
          next_state = WAIT_START;
        end
      end
      WAIT_START: begin
        if (!sync_in) begin
          next_state = WAIT_DONE;
        end else if (to_cnt == TIMEOUT_LAST) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end
      end
      WAIT_DONE: begin
        if (sync_in) begin
          next_state = IDLE;
        end else if (to_cnt == TIMEOUT_LAST) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // Cycles spent in the current wait state. It restarts on every state change
  // so WAIT_START and WAIT_DONE each get the full timeout budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (next_state != state || state == IDLE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  // Values only move on the launch edge, so the driver sees them stable for the
  // whole frame. An empty channel repeats its previous value.
  always_ff @(posedge clk) begin
    if (rst) begin
      value0 <= '0;
      value1 <= '0;
      update <= 1'b0;
    end else begin
      update <= launch;
      if (launch && hold_full[0]) begin
        value0 <= hold_data[0];
      end
      if (launch && hold_full[1]) begin
        value1 <= hold_data[1];
      end
    end
  end

  // Sticky error flags. A clear request wins over anything setting a flag in
  // the same cycle, so software always sees a clean 0 right after clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun  <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else if (clr_flags) begin
      underrun  <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      underrun  <= underrun | underrun_set;
      overrun   <= overrun | (tick && state != IDLE);
      frame_err <= frame_err | timeout;
    end
  end

endmodule
